reg_file_responder: RTL and testbench

- Architectural register file with per-register rename tags for the Tomasulo core.
- Responder side of the dispatch lookup: the dispatcher presents rs1/rs2 and receives V1/V2/Q1/Q2.
- Records the dispatching instruction's destination tag (rename).
- Retires values written by ROB commit; clears all tags on ROB flush.

---
 rtl/reg_file_responder.sv | 105 ++++++++++
 tb/tb_reg_file_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_responder.sv
// Architectural register file with rename tags: zero-latency dual lookup, rename, commit retire, flush.
// Optional macro RF_COMMIT_BYPASS_EN forwards a same-cycle matching commit onto the read ports.
module reg_file_responder #(
    parameter int REG_BW = 5,
    parameter int ROB_BW = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [REG_BW-1:0] rs1,
    input  logic [REG_BW-1:0] rs2,
    output logic [31:0]       V1,
    output logic [31:0]       V2,
    output logic [ROB_BW-1:0] Q1,
    output logic [ROB_BW-1:0] Q2,
    input  logic              rename_flag,
    input  logic [REG_BW-1:0] rename_rd,
    input  logic [ROB_BW-1:0] rename_rob_id,
    input  logic              commit_flag,
    input  logic [REG_BW-1:0] commit_rd,
    input  logic [ROB_BW-1:0] commit_rob_id,
    input  logic [31:0]       commit_val,
    input  logic              flush_flag,
    output logic [REG_BW:0]   busy_cnt
);

    localparam int NREG = 1 << REG_BW;
    localparam logic [REG_BW:0] CNT_ONE = 1;

    logic [31:0]       val      [NREG];
    logic [ROB_BW-1:0] tag      [NREG];
    logic [31:0]       val_next [NREG];
    logic [ROB_BW-1:0] tag_next [NREG];
    logic [REG_BW:0]   busy_next;

    // No handshake: every rename/commit/flush presented with rdy_in=1 is taken at that edge.
    // Order of effects: commit value/tag clear, then flush clears all tags, else rename sets a tag.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            val_next[i] = val[i];
            tag_next[i] = tag[i];
        end
        busy_next = '0;
        if (commit_flag && commit_rd != '0) begin
            val_next[commit_rd] = commit_val;
            if (tag[commit_rd] == commit_rob_id)
                tag_next[commit_rd] = '0;
        end
        if (flush_flag) begin
            for (int i = 0; i < NREG; i++)
                tag_next[i] = '0;
        end else if (rename_flag && rename_rd != '0) begin
            tag_next[rename_rd] = rename_rob_id;
        end
        for (int i = 1; i < NREG; i++) begin
            if (tag_next[i] != '0)
                busy_next = busy_next + CNT_ONE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                val[i] <= '0;
                tag[i] <= '0;
            end
            busy_cnt <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < NREG; i++) begin
                val[i] <= val_next[i];
                tag[i] <= tag_next[i];
            end
            busy_cnt <= busy_next;
        end
    end

`ifdef RF_COMMIT_BYPASS_EN
    logic hit1;
    logic hit2;
    assign hit1 = commit_flag && rdy_in && rs1 == commit_rd && rs1 != '0 && tag[rs1] == commit_rob_id;
    assign hit2 = commit_flag && rdy_in && rs2 == commit_rd && rs2 != '0 && tag[rs2] == commit_rob_id;
`else
    logic hit1;
    logic hit2;
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    // x0 is hardwired to a ready zero regardless of stored contents.
    always_comb begin
        V1 = '0;
        Q1 = '0;
        V2 = '0;
        Q2 = '0;
        if (rs1 != '0) begin
            V1 = hit1 ? commit_val : val[rs1];
            Q1 = hit1 ? '0 : tag[rs1];
        end
        if (rs2 != '0) begin
            V2 = hit2 ? commit_val : val[rs2];
            Q2 = hit2 ? '0 : tag[rs2];
        end
    end

endmodule

// File: tb/tb_reg_file_responder.sv
// Directed bench for reg_file_responder: lookup, rename, commit, flush, stall, reset and x0 handling.
// Expectations for the same-cycle commit read follow RF_COMMIT_BYPASS_EN.
module tb_reg_file_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [4:0]  rs1, rs2;
    logic [31:0] V1, V2;
    logic [3:0]  Q1, Q2;
    logic        rename_flag;
    logic [4:0]  rename_rd;
    logic [3:0]  rename_rob_id;
    logic        commit_flag;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_rob_id;
    logic [31:0] commit_val;
    logic        flush_flag;
    logic [5:0]  busy_cnt;

    int checks = 0;
    int errors = 0;

    reg_file_responder #(.REG_BW(5), .ROB_BW(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rs1(rs1), .rs2(rs2), .V1(V1), .V2(V2), .Q1(Q1), .Q2(Q2),
        .rename_flag(rename_flag), .rename_rd(rename_rd), .rename_rob_id(rename_rob_id),
        .commit_flag(commit_flag), .commit_rd(commit_rd), .commit_rob_id(commit_rob_id),
        .commit_val(commit_val), .flush_flag(flush_flag), .busy_cnt(busy_cnt)
    );

    always #5 clk_in = ~clk_in;

    // Advance one edge; inputs are then changed 1ns after the edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rename_flag = 1'b0;
        commit_flag = 1'b0;
        flush_flag  = 1'b0;
    endtask

    task automatic do_rename(input logic [4:0] rd, input logic [3:0] id);
        rename_flag = 1'b1;
        rename_rd = rd;
        rename_rob_id = id;
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [3:0] id, input logic [31:0] v);
        commit_flag = 1'b1;
        commit_rd = rd;
        commit_rob_id = id;
        commit_val = v;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rs1 = 5'd5; rs2 = 5'd0;
        rename_rd = '0; rename_rob_id = 4'd1; commit_rd = '0; commit_rob_id = '0; commit_val = '0;
        idle();
        step();
        step();
        rst_in = 1'b0;
        #1;
        check("rst_v1", V1, 32'h0);
        check("rst_q1", {28'h0, Q1}, 32'h0);
        check("rst_v2", V2, 32'h0);
        check("rst_q2", {28'h0, Q2}, 32'h0);
        check("rst_busy", {26'h0, busy_cnt}, 32'd0);

        // Rename then matching commit.
        do_rename(5'd3, 4'd7);
        step();
        idle(); rs1 = 5'd3;
        #1;
        check("ren_q1", {28'h0, Q1}, 32'd7);
        check("ren_busy", {26'h0, busy_cnt}, 32'd1);
        do_commit(5'd3, 4'd7, 32'hDEADBEEF);
        step();
        idle();
        #1;
        check("cm_v1", V1, 32'hDEADBEEF);
        check("cm_q1", {28'h0, Q1}, 32'd0);
        check("cm_busy", {26'h0, busy_cnt}, 32'd0);

        // Older commit must not clear a younger rename.
        do_rename(5'd4, 4'd2);
        step();
        do_rename(5'd4, 4'd5);
        step();
        idle();
        do_commit(5'd4, 4'd2, 32'h11);
        step();
        idle(); rs1 = 5'd4;
        #1;
        check("old_v", V1, 32'h11);
        check("old_q", {28'h0, Q1}, 32'd5);
        check("old_busy", {26'h0, busy_cnt}, 32'd1);

        // Same-cycle commit and rename on one register; rename to x0; commit to x0.
        do_commit(5'd6, 4'd3, 32'h22);
        do_rename(5'd6, 4'd9);
        step();
        idle(); rs1 = 5'd6;
        #1;
        check("same_v", V1, 32'h22);
        check("same_q", {28'h0, Q1}, 32'd9);
        check("same_busy", {26'h0, busy_cnt}, 32'd2);
        do_rename(5'd0, 4'd4);
        do_commit(5'd0, 4'd1, 32'h55);
        step();
        idle(); rs2 = 5'd0;
        #1;
        check("x0_q", {28'h0, Q2}, 32'd0);
        check("x0_v", V2, 32'd0);
        check("x0_busy", {26'h0, busy_cnt}, 32'd2);

        // x1..x5 renamed to ids 1..5; x6 still holds 9.
        for (int i = 1; i <= 5; i++) begin
            do_rename(5'(i), 4'(i));
            step();
        end
        idle(); rs1 = 5'd5;
        #1;
        check("pre_flush_busy", {26'h0, busy_cnt}, 32'd6);
        check("pre_flush_q5", {28'h0, Q1}, 32'd5);
        flush_flag = 1'b1;
        do_commit(5'd2, 4'd2, 32'h33);
        do_rename(5'd7, 4'd6);
        step();
        idle(); rs1 = 5'd2; rs2 = 5'd7;
        #1;
        check("fl_v2reg", V1, 32'h33);
        check("fl_q2reg", {28'h0, Q1}, 32'd0);
        check("fl_q7reg", {28'h0, Q2}, 32'd0);
        check("fl_busy", {26'h0, busy_cnt}, 32'd0);
        rs1 = 5'd3; rs2 = 5'd4;
        #1;
        check("fl_keep_v3", V1, 32'hDEADBEEF);
        check("fl_keep_v4", V2, 32'h11);

        // Stall: nothing may change.
        rdy_in = 1'b0;
        do_rename(5'd8, 4'd1);
        do_commit(5'd3, 4'd0, 32'h99);
        step();
        idle(); rs1 = 5'd8;
        #1;
        check("stall_q8", {28'h0, Q1}, 32'd0);
        check("stall_v3", V2 == 32'h11 ? 32'h1 : 32'h0, 32'h1);
        rs2 = 5'd3;
        #1;
        check("stall_keep_v3", V2, 32'hDEADBEEF);
        check("stall_busy", {26'h0, busy_cnt}, 32'd0);
        rdy_in = 1'b1;

        // Same-cycle commit visibility on the read port.
        do_rename(5'd9, 4'd8);
        step();
        idle();
        do_commit(5'd9, 4'd8, 32'h44);
        rs1 = 5'd9;
        #1;
`ifdef RF_COMMIT_BYPASS_EN
        check("byp_v1", V1, 32'h44);
        check("byp_q1", {28'h0, Q1}, 32'd0);
`else
        check("byp_v1", V1, 32'h0);
        check("byp_q1", {28'h0, Q1}, 32'd8);
`endif
        step();
        idle();
        #1;
        check("post_v1", V1, 32'h44);
        check("post_q1", {28'h0, Q1}, 32'd0);
        check("post_busy", {26'h0, busy_cnt}, 32'd0);

        // Reset mid-stream discards pending renames and values.
        do_rename(5'd10, 4'd3);
        step();
        idle(); rs1 = 5'd10;
        #1;
        check("mid_busy", {26'h0, busy_cnt}, 32'd1);
        rst_in = 1'b1;
        do_rename(5'd11, 4'd4);
        step();
        rst_in = 1'b0; idle(); rs2 = 5'd11;
        #1;
        check("mr_q10", {28'h0, Q1}, 32'd0);
        check("mr_q11", {28'h0, Q2}, 32'd0);
        check("mr_busy", {26'h0, busy_cnt}, 32'd0);
        rs1 = 5'd3;
        #1;
        check("mr_v3", V1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
